// File: rtl/seg7_pkg.sv
// Shared types, hex pattern table and one-hot helper for seg7_scan_reader.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

  typedef enum logic [1:0] {
    WAIT,
    SETTLE,
    LOCKED
  } seg7_state_t;

  // Entry i is the segment pattern that displays hex digit i.
  localparam logic [15:0][6:0] SEG7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic seg7_onehot(
    input logic [31:0] v
  );
    return (v != 32'd0) &&
           ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/seg7_scan_reader_if.sv
// Frame output handshake: value, err flags, valid/ready, sticky overflow.
// out_dp is present only when SEG7_DP_EN is defined.
interface seg7_scan_reader_if #(
  parameter int NDIG = 4
);
  logic [4*NDIG-1:0] out_value;
  logic [NDIG-1:0]   out_err;
  logic              out_valid;
  logic              out_ready;
  logic              overflow;
`ifdef SEG7_DP_EN
  logic [NDIG-1:0]   out_dp;

  modport master (
    output out_value, out_err, out_dp,
    output out_valid, overflow,
    input  out_ready
  );
  modport slave (
    input  out_value, out_err, out_dp,
    input  out_valid, overflow,
    output out_ready
  );
`else
  modport master (
    output out_value, out_err,
    output out_valid, overflow,
    input  out_ready
  );
  modport slave (
    input  out_value, out_err,
    input  out_valid, overflow,
    output out_ready
  );
`endif
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to hex nibble decoder.
// Ports: pat_i (7) in; nib_o (4), err_o (1) out; unknown -> nib 0, err 1.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] nib_o,
  output logic       err_o
);

  always_comb begin
    nib_o = 4'd0;
    err_o = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (pat_i == SEG7_TABLE[i]) begin
        nib_o = 4'(i);
        err_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers the hex word shown on a multiplexed 7-seg bus; emits it on out_if.
// Ports: clk, rst_n, seg_in, dig_en, (seg_dp with SEG7_DP_EN), out_if master.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 3,
  parameter int CNT_W      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef SEG7_DP_EN
  input  logic            seg_dp,
`endif
  input  logic [6:0]      seg_in,
  input  logic [NDIG-1:0] dig_en,
  seg7_scan_reader_if.master out_if
);

  seg7_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Current and previous registered samples.
  logic [NDIG-1:0] dig_q, dig_d, dig_p_q, dig_p_d;
  logic [6:0]      seg_q, seg_d, seg_p_q, seg_p_d;

  logic [NDIG-1:0][3:0] slot_v_q, slot_v_d;
  logic [NDIG-1:0]      slot_e_q, slot_e_d;
  logic [NDIG-1:0]      mask_q, mask_d;

  logic [4*NDIG-1:0] val_q, val_d;
  logic [NDIG-1:0]   err_q, err_d;
  logic              vld_q, vld_d;
  logic              ovf_q, ovf_d;

`ifdef SEG7_DP_EN
  logic            dp_q, dp_d, dp_p_q, dp_p_d;
  logic [NDIG-1:0] slot_d_q, slot_d_d;
  logic [NDIG-1:0] odp_q, odp_d;
`endif

  logic [3:0] dec_nib;
  logic       dec_err;
  logic       onehot, same, cap;
  logic       accept, full;

  seg7_pattern_decode u_dec (
    .pat_i (seg_q),
    .nib_o (dec_nib),
    .err_o (dec_err)
  );

  always_comb begin
    dig_d   = dig_en;
    seg_d   = seg_in;
    dig_p_d = dig_q;
    seg_p_d = seg_q;
    same    = (dig_q == dig_p_q) &&
              (seg_q == seg_p_q);
`ifdef SEG7_DP_EN
    dp_d    = seg_dp;
    dp_p_d  = dp_q;
    same    = same && (dp_q == dp_p_q);
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    onehot  = seg7_onehot(32'(dig_q));
    unique case (state_q)
      WAIT: begin
        if (onehot) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (!onehot) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if (same) begin
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          cnt_d   = CNT_W'(1);
        end
      end
      LOCKED: begin
        if (!same) begin
          if (!onehot) begin
            state_d = WAIT;
            cnt_d   = '0;
          end else begin
            state_d = SETTLE;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
    endcase
    // Stability reached: capture on this edge and lock.
    if (state_d == SETTLE &&
        cnt_d == CNT_W'(STABLE_CYC)) begin
      cap     = 1'b1;
      state_d = LOCKED;
    end
  end

  always_comb begin
    slot_v_d = slot_v_q;
    slot_e_d = slot_e_q;
    mask_d   = mask_q;
    val_d    = val_q;
    err_d    = err_q;
    vld_d    = vld_q;
    ovf_d    = ovf_q;
`ifdef SEG7_DP_EN
    slot_d_d = slot_d_q;
    odp_d    = odp_q;
`endif
    accept   = vld_q && out_if.out_ready;
    full     = &mask_q;
    if (accept) vld_d = 1'b0;
    // Output load reads the slots before any capture this cycle.
    if (full) begin
      mask_d = '0;
      if (!vld_q || accept) begin
        val_d = slot_v_q;
        err_d = slot_e_q;
        vld_d = 1'b1;
`ifdef SEG7_DP_EN
        odp_d = slot_d_q;
`endif
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (cap) begin
      for (int i = 0; i < NDIG; i++) begin
        if (dig_q[i]) begin
          slot_v_d[i] = dec_nib;
          slot_e_d[i] = dec_err;
`ifdef SEG7_DP_EN
          slot_d_d[i] = dp_q;
`endif
        end
      end
      mask_d = mask_d | dig_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT;
      cnt_q    <= '0;
      dig_q    <= '0;
      seg_q    <= '0;
      dig_p_q  <= '0;
      seg_p_q  <= '0;
      slot_v_q <= '0;
      slot_e_q <= '0;
      mask_q   <= '0;
      val_q    <= '0;
      err_q    <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef SEG7_DP_EN
      dp_q     <= 1'b0;
      dp_p_q   <= 1'b0;
      slot_d_q <= '0;
      odp_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      seg_q    <= seg_d;
      dig_p_q  <= dig_p_d;
      seg_p_q  <= seg_p_d;
      slot_v_q <= slot_v_d;
      slot_e_q <= slot_e_d;
      mask_q   <= mask_d;
      val_q    <= val_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
`ifdef SEG7_DP_EN
      dp_q     <= dp_d;
      dp_p_q   <= dp_p_d;
      slot_d_q <= slot_d_d;
      odp_q    <= odp_d;
`endif
    end
  end

  assign out_if.out_value = val_q;
  assign out_if.out_err   = err_q;
  assign out_if.out_valid = vld_q;
  assign out_if.overflow  = ovf_q;
`ifdef SEG7_DP_EN
  assign out_if.out_dp    = odp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Scoreboard bench for seg7_scan_reader (NDIG=4, STABLE_CYC=3).
// Expected frames are queued at stimulus time and popped on accept.
module tb_seg7_scan_reader;
  import seg7_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in = '0;
  logic [3:0] dig_en = '0;
`ifdef SEG7_DP_EN
  logic       seg_dp = 1'b0;
`endif

  always #5 clk = ~clk;

  seg7_scan_reader_if #(.NDIG(4)) bus ();

  seg7_scan_reader #(
    .NDIG       (4),
    .STABLE_CYC (3),
    .CNT_W      (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef SEG7_DP_EN
    .seg_dp (seg_dp),
`endif
    .seg_in (seg_in),
    .dig_en (dig_en),
    .out_if (bus)
  );

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  e;
  } frame_t;

  frame_t exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int vcyc = 0;

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h",
                  tag, got, exp);
  endtask

  always @(negedge clk) begin
    frame_t f;
    if (rst_n) begin
      if (bus.out_valid) vcyc++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious", 32'd1, 32'd0);
        end else begin
          f = exp_q.pop_front();
          check("value", 32'(bus.out_value),
                32'(f.v));
          check("err", 32'(bus.out_err),
                32'(f.e));
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(int d,
                      logic [6:0] p,
                      int n);
    dig_en = 4'(1 << d);
    seg_in = p;
    cyc(n);
  endtask

  task automatic blank(int n);
    dig_en = '0;
    seg_in = '0;
    cyc(n);
  endtask

  task automatic scan(logic [6:0] p0,
                      logic [6:0] p1,
                      logic [6:0] p2,
                      logic [6:0] p3);
    show(0, p0, 3);
    show(1, p1, 3);
    show(2, p2, 3);
    show(3, p3, 3);
    blank(2);
  endtask

  task automatic push(logic [15:0] v,
                      logic [3:0] e);
    frame_t f;
    f.v = v;
    f.e = e;
    exp_q.push_back(f);
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0) break;
      cyc(1);
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    cyc(3);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_value", 32'(bus.out_value), 32'd0);
    check("rst_err", 32'(bus.out_err), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_state", 32'(dut.state_q),
          32'(WAIT));
    rst_n = 1'b1;
    cyc(2);

    // Basic scan, valid pulses one cycle.
    vcyc = 0;
    push(16'h4321, 4'b0000);
    scan(7'h06, 7'h5B, 7'h4F, 7'h66);
    drain();
    cyc(3);
    check("pulse_len", 32'(vcyc), 32'd1);

    // Two-cycle digit is below threshold.
    show(0, 7'h7F, 2);
    blank(2);
    check("short_mask", 32'(dut.mask_q), 32'd0);

    // Glitch then stable 9 on digit 0.
    push(16'hCBA9, 4'b0000);
    show(0, 7'h7F, 2);
    show(0, 7'h6F, 3);
    show(1, 7'h77, 3);
    show(2, 7'h7C, 3);
    show(3, 7'h39, 3);
    blank(2);
    drain();

    // Unknown pattern on digit 2.
    push(16'h8065, 4'b0100);
    scan(7'h6D, 7'h7D, 7'h01, 7'h7F);
    drain();

    // Non one-hot enables never capture.
    vcyc = 0;
    dig_en = 4'b0011;
    seg_in = 7'h3F;
    cyc(10);
    check("w2_state", 32'(dut.state_q),
          32'(WAIT));
    dig_en = 4'b0000;
    cyc(10);
    check("w0_state", 32'(dut.state_q),
          32'(WAIT));
    check("w_mask", 32'(dut.mask_q), 32'd0);
    check("w_valid", 32'(vcyc), 32'd0);

    // Backpressure: second frame dropped.
    bus.out_ready = 1'b0;
    push(16'h7E10, 4'b0000);
    scan(7'h3F, 7'h06, 7'h79, 7'h07);
    check("bp_ovf0", 32'(bus.overflow), 32'd0);
    scan(7'h3F, 7'h06, 7'h5B, 7'h4F);
    cyc(1);
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    check("bp_hold", 32'(bus.out_value),
          32'h7E10);
    check("bp_ovf", 32'(bus.overflow), 32'd1);
    bus.out_ready = 1'b1;
    drain();
    cyc(1);
    check("bp_vlow", 32'(bus.out_valid), 32'd0);
    check("bp_sticky", 32'(bus.overflow), 32'd1);

    // Async reset mid-frame.
    show(0, 7'h5E, 3);
    show(1, 7'h79, 3);
    show(2, 7'h71, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(bus.out_valid), 32'd0);
    check("ar_value", 32'(bus.out_value), 32'd0);
    check("ar_err", 32'(bus.out_err), 32'd0);
    check("ar_ovf", 32'(bus.overflow), 32'd0);
    blank(2);
    rst_n = 1'b1;
    vcyc = 0;
    show(2, 7'h71, 3);
    show(3, 7'h3F, 3);
    blank(5);
    check("ar_partial", 32'(vcyc), 32'd0);
    push(16'h0FED, 4'b0000);
    scan(7'h5E, 7'h79, 7'h71, 7'h3F);
    drain();
    check("ar_ovf_end", 32'(bus.overflow), 32'd0);

    cyc(3);
    check("q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
